// File: rtl/conv_pkg.sv
// Shared defaults, state encoding and helpers for the convolution-array feeder.
package conv_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_TAPS   = 4;
  localparam int DEF_LEN_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    STREAM,
    FLUSH
  } conv_state_e;

  // A one-tap array still needs a 1-bit index.
  function automatic int tap_idx_w(input int taps);
    return (taps <= 1) ? 1 : $clog2(taps);
  endfunction

endpackage

// File: rtl/conv_feeder_if.sv
// Control, weight, sample and array-side signals of the convolution feeder.
interface conv_feeder_if
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int LEN_W  = DEF_LEN_W
) ();

  logic                   start;
  logic [LEN_W-1:0]       num_samples;
  logic                   w_valid;
  logic [DATA_W-1:0]      w_data;
  logic                   w_ready;
  logic                   s_valid;
  logic [DATA_W-1:0]      s_data;
  logic                   s_ready;
  logic [DATA_W-1:0]      x_out;
  logic                   x_valid;
  logic [TAPS*DATA_W-1:0] weights;
  logic                   busy;
  logic                   done;

  modport master (
    output start, num_samples, w_valid, w_data, s_valid, s_data,
    input  w_ready, s_ready, x_out, x_valid, weights, busy, done
  );

  modport slave (
    input  start, num_samples, w_valid, w_data, s_valid, s_data,
    output w_ready, s_ready, x_out, x_valid, weights, busy, done
  );

endinterface

// File: rtl/conv_weight_bank.sv
// Register bank holding one filter weight per PE; written one tap at a time.
module conv_weight_bank
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAPS   = DEF_TAPS,
  localparam int IDX_W = tap_idx_w(TAPS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [IDX_W-1:0]       idx,
  input  logic [DATA_W-1:0]      wdata,
  output logic [TAPS*DATA_W-1:0] weights
);

  logic [DATA_W-1:0] bank_q [TAPS];
  logic [DATA_W-1:0] bank_d [TAPS];

  always_comb begin
    bank_d = bank_q;
    for (int k = 0; k < TAPS; k++) begin
      if (we && (int'(idx) == k)) bank_d[k] = wdata;
    end
  end

  // NOTE: this bank is a few flops rather than a RAM, so it is cleared on reset;
  // an aborted frame must never leave stale taps driving the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bank_q <= '{default: '0};
    else        bank_q <= bank_d;
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_out
    assign weights[k*DATA_W +: DATA_W] = bank_q[k];
  end

endmodule

// File: rtl/conv_feeder.sv
// Feeds a systolic convolution array: loads TAPS weights, streams a frame of
// samples onto x, then appends TAPS-1 zero beats to drain the partial sums.
module conv_feeder
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int LEN_W  = DEF_LEN_W
) (
  input logic         clk,
  input logic         rst_n,
  conv_feeder_if.slave bus
);

  localparam int IDX_W   = tap_idx_w(TAPS);
  localparam bit ONE_TAP = (TAPS == 1);

  conv_state_e       state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  scnt_q, scnt_d;
  logic [IDX_W-1:0]  wcnt_q, wcnt_d;
  logic [IDX_W-1:0]  fcnt_q, fcnt_d;
  logic [DATA_W-1:0] x_out_q, x_out_d;
  logic              x_valid_q, x_valid_d;
  logic              done_q, done_d;

  logic w_ready, s_ready, w_hs, s_hs;
  logic last_w, last_s, last_f;
  logic [TAPS*DATA_W-1:0] weights;

  assign w_ready = (state_q == LOAD_W);
  assign s_ready = (state_q == STREAM);
  assign w_hs    = bus.w_valid && w_ready;
  assign s_hs    = bus.s_valid && s_ready;
  assign last_w  = (int'(wcnt_q) == TAPS - 1);
  // Counting up to len-1 keeps a full-scale length from needing an extra bit.
  assign last_s  = (scnt_q == len_q - LEN_W'(1));
  assign last_f  = (int'(fcnt_q) == TAPS - 2);

  // NOTE: every _d gets its hold value first, so no path through the case
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    scnt_d    = scnt_q;
    wcnt_d    = wcnt_q;
    fcnt_d    = fcnt_q;
    x_out_d   = x_out_q;
    x_valid_d = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD_W;
          len_d   = bus.num_samples;
          wcnt_d  = '0;
        end
      end

      LOAD_W: begin
        if (w_hs) begin
          wcnt_d = wcnt_q + IDX_W'(1);
          if (last_w) begin
            wcnt_d = '0;
            scnt_d = '0;
            fcnt_d = '0;
            if (len_q != '0) begin
              state_d = STREAM;
            end else if (ONE_TAP) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = FLUSH;
            end
          end
        end
      end

      STREAM: begin
        if (s_hs) begin
          x_out_d   = bus.s_data;
          x_valid_d = 1'b1;
          scnt_d    = scnt_q + LEN_W'(1);
          if (last_s) begin
            scnt_d = '0;
            if (ONE_TAP) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = FLUSH;
            end
          end
        end
      end

      FLUSH: begin
        x_out_d   = '0;
        x_valid_d = 1'b1;
        fcnt_d    = fcnt_q + IDX_W'(1);
        if (last_f) begin
          fcnt_d  = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      scnt_q    <= '0;
      wcnt_q    <= '0;
      fcnt_q    <= '0;
      x_out_q   <= '0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      scnt_q    <= scnt_d;
      wcnt_q    <= wcnt_d;
      fcnt_q    <= fcnt_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
    end
  end

  conv_weight_bank #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (w_hs),
    .idx     (wcnt_q),
    .wdata   (bus.w_data),
    .weights (weights)
  );

  assign bus.w_ready = w_ready;
  assign bus.s_ready = s_ready;
  assign bus.x_out   = x_out_q;
  assign bus.x_valid = x_valid_q;
  assign bus.weights = weights;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;

endmodule
